// File: rtl/kan_layer_sequencer.sv
// kan_layer_sequencer
// Runs one inference of a 3-layer KAN through a single shared edge-function
// unit (EU). The sequencer walks (layer, output neuron j, input i) in
// ascending order, issues one EU request per edge, accumulates each neuron
// sum and stores the saturated activations in two ping-pong buffers.
//
// Ports:
//   clk, reset                 rising-edge clock, async active-low reset
//   in_valid/in_ready/in_data  feature vector handshake, x0 in LSBs
//   eu_req/eu_layer/eu_out_idx/eu_in_idx/eu_x   edge evaluation request
//   eu_ack/eu_y                EU result (ack may arrive in the request cycle)
//   out_valid/out_ready/out_data   result handshake, y0 in LSBs
//   busy                       high whenever not IDLE
//   err                        one-cycle pulse when the EU fails to answer
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for an input vector (in_ready=1)
// RUN   | requesting edges from the EU and accumulating neuron sums
// DONE  | result presented on out_data until out_ready
module kan_layer_sequencer #(
    parameter int IN_FEATURES  = 2,
    parameter int L1_FEATURES  = 3,
    parameter int L2_FEATURES  = 3,
    parameter int OUT_FEATURES = 1,
    parameter int DATA_W       = 16,
    parameter int ACC_W        = 20,
    parameter int TIMEOUT      = 64
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [IN_FEATURES*DATA_W-1:0]  in_data,
    output logic                           eu_req,
    output logic [1:0]                     eu_layer,
    output logic [3:0]                     eu_out_idx,
    output logic [3:0]                     eu_in_idx,
    output logic [DATA_W-1:0]              eu_x,
    input  logic                           eu_ack,
    input  logic [DATA_W-1:0]              eu_y,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [OUT_FEATURES*DATA_W-1:0] out_data,
    output logic                           busy,
    output logic                           err
);

    localparam int MAX_A  = (IN_FEATURES > L1_FEATURES) ? IN_FEATURES : L1_FEATURES;
    localparam int MAX_B  = (L2_FEATURES > OUT_FEATURES) ? L2_FEATURES : OUT_FEATURES;
    localparam int MAXF   = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int IDX_W  = (MAXF > 1) ? $clog2(MAXF) : 1;
    localparam int WAIT_W = $clog2(TIMEOUT) + 1;

    localparam logic [WAIT_W-1:0]      WAIT_LOAD = WAIT_W'(TIMEOUT - 1);
    localparam logic signed [ACC_W-1:0] SAT_HI   = ACC_W'((2 ** (DATA_W - 1)) - 1);
    localparam logic signed [ACC_W-1:0] SAT_LO   = ~SAT_HI;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]                     state;
    logic [1:0]                     layer;
    logic [3:0]                     j_idx;
    logic [3:0]                     i_idx;
    logic signed [ACC_W-1:0]        acc;
    logic signed [ACC_W-1:0]        acc_next;
    logic [WAIT_W-1:0]              wait_cnt;
    logic                           src_sel;   // 0: A is source, B is destination
    logic [DATA_W-1:0]              buf_a [MAXF];
    logic [DATA_W-1:0]              buf_b [MAXF];
    logic [DATA_W-1:0]              src_x;
    logic [DATA_W-1:0]              sat_next;
    logic [3:0]                     last_i;
    logic [3:0]                     last_j;
    logic [OUT_FEATURES*DATA_W-1:0] out_next;

    function automatic logic [DATA_W-1:0] sat(input logic signed [ACC_W-1:0] v);
        if (v > SAT_HI)
            return SAT_HI[DATA_W-1:0];
        else if (v < SAT_LO)
            return SAT_LO[DATA_W-1:0];
        else
            return v[DATA_W-1:0];
    endfunction

    always_comb begin
        last_i = 4'(IN_FEATURES - 1);
        last_j = 4'(L1_FEATURES - 1);
        case (layer)
            2'd1: begin
                last_i = 4'(L1_FEATURES - 1);
                last_j = 4'(L2_FEATURES - 1);
            end
            2'd2: begin
                last_i = 4'(L2_FEATURES - 1);
                last_j = 4'(OUT_FEATURES - 1);
            end
            default: ;
        endcase

        src_x    = src_sel ? buf_b[i_idx[IDX_W-1:0]] : buf_a[i_idx[IDX_W-1:0]];
        acc_next = acc + {{(ACC_W - DATA_W){eu_y[DATA_W-1]}}, eu_y};
        sat_next = sat(acc_next);

        // The neuron being finished this cycle is not yet in the buffer,
        // so the output word is assembled from the buffer plus sat_next.
        out_next = '0;
        for (int k = 0; k < OUT_FEATURES; k++) begin
            if (4'(k) == j_idx)
                out_next[k*DATA_W +: DATA_W] = sat_next;
            else
                out_next[k*DATA_W +: DATA_W] = src_sel ? buf_a[k] : buf_b[k];
        end
    end

    assign in_ready   = (state == S_IDLE);
    assign eu_req     = (state == S_RUN);
    assign out_valid  = (state == S_DONE);
    assign busy       = (state != S_IDLE);
    assign eu_layer   = layer;
    assign eu_out_idx = j_idx;
    assign eu_in_idx  = i_idx;
    assign eu_x       = src_x;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= S_IDLE;
            layer    <= '0;
            j_idx    <= '0;
            i_idx    <= '0;
            acc      <= '0;
            wait_cnt <= '0;
            src_sel  <= 1'b0;
            out_data <= '0;
            err      <= 1'b0;
            for (int k = 0; k < MAXF; k++) begin
                buf_a[k] <= '0;
                buf_b[k] <= '0;
            end
        end else begin
            err <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        for (int k = 0; k < IN_FEATURES; k++)
                            buf_a[k] <= in_data[k*DATA_W +: DATA_W];
                        layer    <= '0;
                        j_idx    <= '0;
                        i_idx    <= '0;
                        acc      <= '0;
                        src_sel  <= 1'b0;
                        wait_cnt <= WAIT_LOAD;
                        state    <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (eu_ack) begin
                        wait_cnt <= WAIT_LOAD;
                        if (i_idx != last_i) begin
                            i_idx <= i_idx + 4'd1;
                            acc   <= acc_next;
                        end else begin
                            i_idx <= '0;
                            acc   <= '0;
                            if (src_sel)
                                buf_a[j_idx[IDX_W-1:0]] <= sat_next;
                            else
                                buf_b[j_idx[IDX_W-1:0]] <= sat_next;
                            if (j_idx != last_j) begin
                                j_idx <= j_idx + 4'd1;
                            end else begin
                                j_idx <= '0;
                                if (layer == 2'd2) begin
                                    out_data <= out_next;
                                    state    <= S_DONE;
                                end else begin
                                    layer   <= layer + 2'd1;
                                    src_sel <= ~src_sel;
                                end
                            end
                        end
                    end else if (wait_cnt == '0) begin
                        err   <= 1'b1;
                        state <= S_IDLE;
                    end else begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
                end
                S_DONE: begin
                    if (out_ready)
                        state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_kan_layer_sequencer.sv
module tb_kan_layer_sequencer;

    localparam int IN_F = 2, L1_F = 3, L2_F = 3, OUT_F = 1, DW = 16, AW = 20, TO = 64;

    logic                 clk;
    logic                 reset;
    logic                 in_valid;
    logic                 in_ready;
    logic [IN_F*DW-1:0]   in_data;
    logic                 eu_req;
    logic [1:0]           eu_layer;
    logic [3:0]           eu_out_idx;
    logic [3:0]           eu_in_idx;
    logic [DW-1:0]        eu_x;
    logic                 eu_ack;
    logic [DW-1:0]        eu_y;
    logic                 out_valid;
    logic                 out_ready;
    logic [OUT_F*DW-1:0]  out_data;
    logic                 busy;
    logic                 err;

    kan_layer_sequencer #(
        .IN_FEATURES(IN_F), .L1_FEATURES(L1_F), .L2_FEATURES(L2_F), .OUT_FEATURES(OUT_F),
        .DATA_W(DW), .ACC_W(AW), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .eu_req(eu_req), .eu_layer(eu_layer), .eu_out_idx(eu_out_idx),
        .eu_in_idx(eu_in_idx), .eu_x(eu_x), .eu_ack(eu_ack), .eu_y(eu_y),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .busy(busy), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int                 l;
        int                 j;
        int                 i;
        logic signed [15:0] x;
    } edge_rec_t;

    edge_rec_t exp_q[$];
    int checks   = 0;
    int failures = 0;

    int eu_mode   = 0;
    int delay_cfg = 0;
    int cur_delay = 0;
    int wcnt      = 0;
    bit ack_noise = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // The bench's own EU: identity, negation, or an index-dependent affine map.
    function automatic logic signed [15:0] eu_fn(input int mode, input int l, input int j,
                                                 input int i, input logic signed [15:0] x);
        int v;
        case (mode)
            0:       v = x;
            1:       v = -int'(x);
            default: v = int'(x >>> 1) + 100 * j - 37 * i + 11 * l;
        endcase
        return 16'(v);
    endfunction

    function automatic int clamp16(input int s);
        if (s > 32767) return 32767;
        if (s < -32768) return -32768;
        return s;
    endfunction

    // Reference inference: plain integer arithmetic layer by layer, also
    // recording the expected edge order and operands.
    function automatic void build_model(input logic signed [15:0] x0, input logic signed [15:0] x1,
                                        input int mode, output logic signed [15:0] y);
        int act[4];
        int nxt[4];
        int fin, fout, s;
        act[0] = x0;
        act[1] = x1;
        act[2] = 0;
        act[3] = 0;
        exp_q.delete();
        for (int l = 0; l < 3; l++) begin
            fin  = (l == 0) ? IN_F : ((l == 1) ? L1_F : L2_F);
            fout = (l == 0) ? L1_F : ((l == 1) ? L2_F : OUT_F);
            for (int j = 0; j < 4; j++) nxt[j] = 0;
            for (int j = 0; j < fout; j++) begin
                s = 0;
                for (int i = 0; i < fin; i++) begin
                    exp_q.push_back('{l, j, i, 16'(act[i])});
                    s += int'(eu_fn(mode, l, j, i, 16'(act[i])));
                end
                nxt[j] = clamp16(s);
            end
            act = nxt;
        end
        y = 16'(act[0]);
    endfunction

    function automatic int pick_delay();
        if (delay_cfg >= 0) return delay_cfg;
        return int'($urandom_range(0, 3));
    endfunction

    // EU responder: answers each request after cur_delay wait cycles.
    always @(negedge clk) begin
        if (eu_ack) begin
            wcnt      = 0;
            cur_delay = pick_delay();
        end
        if (eu_req) begin
            if (wcnt >= cur_delay) begin
                eu_ack = 1'b1;
                eu_y   = eu_fn(eu_mode, int'(eu_layer), int'(eu_out_idx), int'(eu_in_idx), eu_x);
            end else begin
                eu_ack = 1'b0;
                wcnt++;
            end
        end else begin
            wcnt   = 0;
            eu_ack = ack_noise ? 1'($urandom_range(0, 1)) : 1'b0;
            eu_y   = 16'($urandom);
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"}, in_ready, 1);
        check({tag, "_eu_req"}, eu_req, 0);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_err"}, err, 0);
        check({tag, "_out_data"}, out_data, 0);
    endtask

    task automatic run_vector(input logic signed [15:0] x0, input logic signed [15:0] x1,
                              input int mode, input int dly, input int hold, input bit exp_to,
                              input int abort_at, input bit noise, input int exp_lat);
        logic signed [15:0] y_exp;
        int  n, req_cycles;
        bit  done;
        edge_rec_t h;
        build_model(x0, x1, mode, y_exp);
        eu_mode   = mode;
        delay_cfg = dly;
        cur_delay = pick_delay();
        wcnt      = 0;
        ack_noise = noise;
        out_ready = 1'b1;

        n = 0;
        while (!in_ready && n < 100) begin
            @(negedge clk); #1;
            n++;
        end
        check("in_ready_before_start", in_ready, 1);
        in_data  = {x1, x0};
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        if (noise) in_data = $urandom;

        req_cycles = 0;
        done = 0;
        for (n = 1; n <= 400 && !done; n++) begin
            @(negedge clk); #1;
            if (abort_at == n) begin
                reset = 1'b0;
                #1;
                check_reset_outputs("abort");
                @(negedge clk);
                reset = 1'b1;
                done = 1;
            end else if (eu_req) begin
                req_cycles++;
                check("busy_in_run", busy, 1);
                if (exp_q.size() == 0) begin
                    check("extra_request", req_cycles, 0);
                end else begin
                    h = exp_q[0];
                    check("edge_req", {eu_layer, eu_out_idx, eu_in_idx, eu_x},
                          {2'(h.l), 4'(h.j), 4'(h.i), h.x});
                    if (eu_ack) void'(exp_q.pop_front());
                end
                if (noise) begin
                    in_valid  = 1'($urandom_range(0, 1));
                    in_data   = $urandom;
                    out_ready = 1'($urandom_range(0, 1));
                end
            end else if (err) begin
                in_valid = 1'b0;
                check("timeout_expected", exp_to, 1);
                check("timeout_cycle", n, TO + 1);
                check("timeout_in_ready", in_ready, 1);
                check("timeout_out_valid", out_valid, 0);
                @(negedge clk); #1;
                check("err_single_pulse", err, 0);
                check("after_timeout_out_valid", out_valid, 0);
                done = 1;
            end else if (out_valid) begin
                in_valid = 1'b0;
                check("no_timeout_expected", exp_to, 0);
                if (exp_lat > 0) begin
                    check("out_latency", n, exp_lat);
                    check("req_cycle_count", req_cycles, exp_lat - 1);
                end
                check("edges_left", exp_q.size(), 0);
                check("out_data", out_data, {y_exp});
                check("in_ready_in_done", in_ready, 0);
                if (hold > 0) begin
                    out_ready = 1'b0;
                    for (int k = 0; k < hold; k++) begin
                        @(negedge clk); #1;
                        check("hold_out_valid", out_valid, 1);
                        check("hold_out_data", out_data, {y_exp});
                        check("hold_in_ready", in_ready, 0);
                    end
                end
                out_ready = 1'b1;
                @(negedge clk); #1;
                check("after_accept_out_valid", out_valid, 0);
                check("after_accept_in_ready", in_ready, 1);
                done = 1;
            end else begin
                check("busy_in_run", busy, 1);
                done = 1;
            end
        end
        check("vector_finished", done, 1);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        ack_noise = 0;
    endtask

    logic signed [15:0] y_pin;
    logic signed [15:0] rx0, rx1;

    initial begin
        reset     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        eu_ack    = 1'b0;
        eu_y      = '0;

        repeat (3) @(negedge clk);
        #1;
        check_reset_outputs("reset");
        reset = 1'b1;
        @(negedge clk);

        // Hand-computed values that pin the reference model.
        build_model(16'sd50, 16'sd30, 0, y_pin);
        check("model_identity", {y_pin}, 16'h02D0);
        build_model(16'sd50, 16'sd30, 1, y_pin);
        check("model_negate", {y_pin}, 16'hFD30);
        build_model(16'sh4000, 16'sh4000, 0, y_pin);
        check("model_sat_hi", {y_pin}, 16'h7FFF);
        build_model(16'shC000, 16'shC000, 0, y_pin);
        check("model_sat_lo", {y_pin}, 16'h8000);

        run_vector(16'sd50, 16'sd30, 0, 0, 0, 0, 0, 0, 19);
        run_vector(16'sd50, 16'sd30, 1, 0, 0, 0, 0, 0, 19);
        run_vector(16'sh4000, 16'sh4000, 0, 0, 0, 0, 0, 0, 19);
        run_vector(16'shC000, 16'shC000, 0, 0, 0, 0, 0, 0, 19);
        run_vector(16'sd50, 16'sd30, 0, 3, 0, 0, 0, 0, 73);
        run_vector(16'sd50, 16'sd30, 0, 1000, 0, 1, 0, 0, 0);
        run_vector(16'sd50, 16'sd30, 0, 0, 0, 0, 0, 0, 19);
        run_vector(16'sd50, 16'sd30, 0, 0, 10, 0, 0, 0, 19);
        run_vector(16'sd50, 16'sd30, 0, 0, 0, 0, 5, 0, 0);
        run_vector(-16'sd123, 16'sd77, 2, 0, 0, 0, 0, 0, 19);

        for (int t = 0; t < 20; t++) begin
            rx0 = 16'($urandom);
            rx1 = 16'($urandom);
            run_vector(rx0, rx1, int'($urandom_range(0, 2)), -1,
                       int'($urandom_range(0, 3)), 0, 0, 1, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/kan_layer_sequencer.md
Name: kan_layer_sequencer

Overview:
- Sequences one inference of the 3-layer KAN (IN_FEATURES -> L1_FEATURES -> L2_FEATURES -> OUT_FEATURES) through a single shared edge-function unit (EU).
- Walks layer, output neuron and input index in order, and issues one EU request per edge phi(l,j,i)(x_i).
- Accumulates the EU results into each neuron sum and stores layer activations in ping-pong buffers.
- Sits between the feature source (valid/ready) and the result consumer (valid/ready).

Parameters:
IN_FEATURES, 2, layer-0 input count
L1_FEATURES, 3, hidden layer 1 width
L2_FEATURES, 3, hidden layer 2 width
OUT_FEATURES, 1, output count
DATA_W, 16, activation / EU word width (signed two's complement)
ACC_W, 20, accumulator width
TIMEOUT, 64, max cycles eu_req may wait for eu_ack

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
in_valid  in  1  input vector valid
in_ready  out  1  sequencer can accept a vector
in_data  in  IN_FEATURES*DATA_W  packed features, x0 in LSBs
eu_req  out  1  edge evaluation request
eu_layer  out  2  layer index 0..2
eu_out_idx  out  4  output neuron index j
eu_in_idx  out  4  input index i
eu_x  out  DATA_W  operand x_i
eu_ack  in  1  result valid (may be same cycle as eu_req)
eu_y  in  DATA_W  signed edge result
out_valid  out  1  result vector valid
out_ready  in  1  consumer accepts result
out_data  out  OUT_FEATURES*DATA_W  packed outputs, y0 in LSBs
busy  out  1  high in any state except IDLE
err  out  1  one-cycle pulse on EU timeout

Behaviour:
- Reset (reset=0, async) values:
  - state=IDLE, in_ready=1, eu_req=0, out_valid=0, busy=0, err=0.
  - out_data=0, accumulator=0, all buffer entries=0, counters=0.
  - Reset asserted mid-operation aborts immediately. No partial result is emitted.
- States:
  - IDLE: in_ready=1. On in_valid: capture in_data into buffer A, set l=j=i=0, clear acc, go to RUN.
  - RUN: eu_req=1. eu_layer/eu_out_idx/eu_in_idx/eu_x hold stable until eu_ack. eu_x = source buffer[i].
    - On eu_ack: acc_next = acc + sign-extend(eu_y).
    - i not last: i++ and the request stays asserted; a zero-wait EU gives one edge per cycle.
    - i last: write sat(acc_next) to destination buffer[j], clear acc, i=0.
      - j not last: j++.
      - j last: swap buffers, l++, j=0.
    - Last edge of layer 2 accepted: out_data <= sat values of the output layer, go to DONE.
  - DONE: out_valid=1 and out_data held stable until out_ready. On out_ready: out_valid=0, go to IDLE.
- Fan-in/fan-out per layer:
  - Layer 0: fan-in IN_FEATURES, fan-out L1_FEATURES.
  - Layer 1: L1 -> L2.
  - Layer 2: L2 -> OUT.
  - Defaults give 2*3 + 3*3 + 3*1 = 18 edges.
- Latency: capture at edge T0; with eu_ack tied high, requests occupy cycles T0+1..T0+18 and out_valid=1 from T0+19. Each EU wait cycle adds one.
- Saturation: sat() clamps ACC_W signed to [-2^(DATA_W-1), 2^(DATA_W-1)-1]. The accumulator itself never wraps at default sizes.
- Timeout:
  - A wait counter counts consecutive cycles of eu_req=1 without eu_ack.
  - Reaching TIMEOUT: err pulses for 1 cycle, eu_req drops, state goes to IDLE, out_valid stays 0, buffers are retained.
  - The counter resets on each ack.
- Simultaneous events:
  - in_valid while not IDLE is ignored (in_ready=0).
  - out_ready while not DONE is ignored.
  - eu_ack while eu_req=0 is ignored.
- Buffers: two entries of max(IN,L1,L2,OUT) x DATA_W each. A layer's source and destination are never the same buffer.

Test Plan:
- Identity EU (eu_y=eu_x, ack=1), in_data x0=50, x1=30 -> L1=80 each, L2=240 each, out_data=720 (16'h02D0), out_valid at T0+19, 18 eu_req cycles with index order (l,j,i) ascending.
- Negating EU (eu_y=-eu_x), x=50,30 -> out_data=-720 (16'hFD30).
- Identity EU, x0=x1=16'h4000 -> every layer saturates, out_data=16'h7FFF. x0=x1=16'hC000 -> 16'h8000.
- EU acks on the 4th request cycle -> eu_req and indices are stable while waiting, out_valid at T0+73, same 720 result.
- EU never acks, TIMEOUT=64 -> err pulses once after 64 req cycles, then IDLE, in_ready=1, out_valid=0. The next vector completes normally.
- out_ready held low 10 cycles in DONE -> out_valid and out_data stable, in_ready=0. reset pulled low mid-RUN -> all outputs at reset values immediately.
